// File: rtl/ramp_settle_monitor.sv
// Settling monitor: tracks |goal - sample| against a tolerance band and reports
// settled / timeout status and settling time. Optional relock: RAMP_SETTLE_RELOCK_EN.
module ramp_settle_monitor #(
  parameter int unsigned signal_width  = 12,
  parameter int unsigned settle_cycles = 16,
  parameter int unsigned time_width    = 16
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    clock_enable,
  input  logic                    start,
  input  logic [signal_width-1:0] goal,
  input  logic [signal_width-1:0] sample,
  input  logic [signal_width-1:0] tolerance,
  input  logic [time_width-1:0]   timeout,
  output logic                    busy,
  output logic                    settled,
  output logic                    fault,
  output logic [time_width-1:0]   ramp_time
`ifdef RAMP_SETTLE_RELOCK_EN
  ,
  output logic                    settle_lost
`endif
);

  localparam int unsigned BAND_W = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(settle_cycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_SETTLED,
    ST_FAULT
  } state_t;

  state_t                  state_q, state_d;
  logic [signal_width-1:0] goal_q, goal_d;
  logic [time_width-1:0]   elapsed_q, elapsed_d;
  logic [BAND_W-1:0]       band_cnt_q, band_cnt_d;
  logic [time_width-1:0]   ramp_time_q, ramp_time_d;
  logic                    busy_q, busy_d;
  logic                    settled_q, settled_d;
  logic                    fault_q, fault_d;
  logic                    settle_lost_q, settle_lost_d;

  logic [signal_width:0]   abs_err;
  logic                    in_band;
  logic [time_width-1:0]   elapsed_inc;
  logic                    settle_hit;
  logic                    timeout_hit;
  logic                    goal_moved;

  // Error is taken against the captured goal; the extra bit keeps the
  // difference of two full-scale values from wrapping.
  always_comb begin
    if (goal_q >= sample) begin
      abs_err = {1'b0, goal_q} - {1'b0, sample};
    end else begin
      abs_err = {1'b0, sample} - {1'b0, goal_q};
    end
  end

  assign in_band     = (abs_err <= {1'b0, tolerance});
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + time_width'(1);
  assign settle_hit  = in_band && (band_cnt_q == BAND_LAST);
  assign timeout_hit = (timeout != '0) && (elapsed_inc >= timeout);
  assign goal_moved  = (goal != goal_q);

  always_comb begin
    // NOTE: every next-state variable starts from its held value so that no
    // branch below can leave one unassigned and infer a latch.
    state_d       = state_q;
    goal_d        = goal_q;
    elapsed_d     = elapsed_q;
    band_cnt_d    = band_cnt_q;
    ramp_time_d   = ramp_time_q;
    settle_lost_d = settle_lost_q;

    if (start) begin
      state_d       = ST_TRACK;
      goal_d        = goal;
      elapsed_d     = '0;
      band_cnt_d    = '0;
      settle_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_TRACK: begin
          // A moved goal restarts the measurement and is not counted as a sample.
          if (goal_moved) begin
            goal_d     = goal;
            elapsed_d  = '0;
            band_cnt_d = '0;
          end else if (clock_enable) begin
            elapsed_d  = elapsed_inc;
            band_cnt_d = in_band ? band_cnt_q + BAND_W'(1) : '0;
            if (settle_hit) begin
              state_d     = ST_SETTLED;
              ramp_time_d = elapsed_inc;
              band_cnt_d  = '0;
            end else if (timeout_hit) begin
              state_d = ST_FAULT;
            end
          end
        end
        ST_SETTLED: begin
`ifdef RAMP_SETTLE_RELOCK_EN
          if (goal_moved || (clock_enable && !in_band)) begin
            state_d    = ST_TRACK;
            elapsed_d  = '0;
            band_cnt_d = '0;
            if (clock_enable && !in_band) begin
              settle_lost_d = 1'b1;
            end
          end
`endif
        end
        default: begin
          // IDLE and FAULT wait for start.
        end
      endcase
    end

    busy_d    = (state_d == ST_TRACK);
    settled_d = (state_d == ST_SETTLED);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      goal_q        <= '0;
      elapsed_q     <= '0;
      band_cnt_q    <= '0;
      ramp_time_q   <= '0;
      busy_q        <= 1'b0;
      settled_q     <= 1'b0;
      fault_q       <= 1'b0;
      settle_lost_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so ordering of these lines cannot change behaviour.
      state_q       <= state_d;
      goal_q        <= goal_d;
      elapsed_q     <= elapsed_d;
      band_cnt_q    <= band_cnt_d;
      ramp_time_q   <= ramp_time_d;
      busy_q        <= busy_d;
      settled_q     <= settled_d;
      fault_q       <= fault_d;
      settle_lost_q <= settle_lost_d;
    end
  end

  assign busy      = busy_q;
  assign settled   = settled_q;
  assign fault     = fault_q;
  assign ramp_time = ramp_time_q;

`ifdef RAMP_SETTLE_RELOCK_EN
  assign settle_lost = settle_lost_q;
`else
  logic unused_lost;
  assign unused_lost = settle_lost_q;
`endif

endmodule

// File: tb/tb_ramp_settle_monitor.sv
// Directed scoreboard bench for ramp_settle_monitor (settle_cycles=4).
// Relock scenarios run when RAMP_SETTLE_RELOCK_EN is defined.
module tb_ramp_settle_monitor;

  localparam int SW = 12;
  localparam int SC = 4;
  localparam int TW = 16;

  logic          aclk = 1'b0;
  logic          reset;
  logic          clock_enable;
  logic          start;
  logic [SW-1:0] goal;
  logic [SW-1:0] sample;
  logic [SW-1:0] tolerance;
  logic [TW-1:0] timeout;
  logic          busy;
  logic          settled;
  logic          fault;
  logic [TW-1:0] ramp_time;
  logic          lost_obs;

`ifdef RAMP_SETTLE_RELOCK_EN
  logic settle_lost;
  assign lost_obs = settle_lost;
`else
  assign lost_obs = 1'b0;
`endif

  always #5 aclk = ~aclk;

  ramp_settle_monitor #(
    .signal_width (SW),
    .settle_cycles(SC),
    .time_width   (TW)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .clock_enable(clock_enable),
    .start       (start),
    .goal        (goal),
    .sample      (sample),
    .tolerance   (tolerance),
    .timeout     (timeout),
    .busy        (busy),
    .settled     (settled),
    .fault       (fault),
    .ramp_time   (ramp_time)
`ifdef RAMP_SETTLE_RELOCK_EN
    ,
    .settle_lost (settle_lost)
`endif
  );

  typedef struct {
    string         tag;
    logic          b;
    logic          s;
    logic          f;
    logic          l;
    logic [TW-1:0] rt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow: queue size %0d expected nonzero", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert ({busy, settled, fault, lost_obs, ramp_time} === {e.b, e.s, e.f, e.l, e.rt}) else begin
        errors++;
        $error("FAIL %s: busy/settled/fault/lost/ramp_time observed %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
               e.tag, busy, settled, fault, lost_obs, ramp_time, e.b, e.s, e.f, e.l, e.rt);
      end
    end
  endtask

  // Drive one cycle of stimulus, record the outputs it must produce, then compare.
  task automatic x(input logic ce, input logic st, input logic [SW-1:0] smp, input string tag,
                   input logic b, input logic s, input logic f, input logic l,
                   input logic [TW-1:0] rt);
    exp_t e;
    e = '{tag, b, s, f, l, rt};
    clock_enable = ce;
    start        = st;
    sample       = smp;
    sb.push_back(e);
    @(posedge aclk);
    #1;
    start = 1'b0;
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] last_rt;
    reset        = 1'b1;
    clock_enable = 1'b1;
    start        = 1'b0;
    goal         = SW'(1000);
    sample       = '0;
    tolerance    = SW'(2);
    timeout      = '0;
    #2;

    x(1, 0, 0, "reset_state", 0, 0, 0, 0, 0);
    reset = 1'b0;
    x(1, 0, 0, "idle_hold", 0, 0, 0, 0, 0);

    // Basic settle: first in-band sample is 998, 4th in-band is the second 1000.
    x(1, 1, 0,    "t1_start", 1, 0, 0, 0, 0);
    x(1, 0, 996,  "t1_s996",  1, 0, 0, 0, 0);
    x(1, 0, 997,  "t1_s997",  1, 0, 0, 0, 0);
    x(1, 0, 998,  "t1_s998",  1, 0, 0, 0, 0);
    x(1, 0, 999,  "t1_s999",  1, 0, 0, 0, 0);
    x(1, 0, 1000, "t1_s1000", 1, 0, 0, 0, 0);
    x(1, 0, 1000, "t1_settle", 0, 1, 0, 0, 6);
    x(1, 0, 1000, "t1_hold",  0, 1, 0, 0, 6);

    // Alternating 998/1003 never settles; timeout raised to 50 while tracking.
    reset = 1'b1;
    x(1, 0, 0, "t2_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    x(1, 1, 0, "t2_start", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      x(1, 0, (i % 2) ? SW'(998) : SW'(1003), "t2_no_timeout", 1, 0, 0, 0, 0);
    end
    timeout = TW'(50);
    for (int i = 21; i <= 49; i++) begin
      x(1, 0, (i % 2) ? SW'(998) : SW'(1003), "t2_tracking", 1, 0, 0, 0, 0);
    end
    x(1, 0, 1003, "t2_fault",      0, 0, 1, 0, 0);
    x(1, 0, 1000, "t2_fault_hold", 0, 0, 1, 0, 0);

    // Start from FAULT, strobe every 4th cycle.
    timeout = '0;
    x(1, 1, 1000, "t3_start_from_fault", 1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) x((k % 4) == 0, 0, 1000, "t3_strobe_track", 1, 0, 0, 0, 0);
      else        x(1, 0, 1000, "t3_strobe_settle", 0, 1, 0, 0, 4);
    end

    // Full-scale error with full-scale tolerance is in band.
    goal      = '0;
    tolerance = SW'(4095);
    x(1, 1, 0, "t4_start_a", 1, 0, 0, 0, 4);
    for (int i = 1; i <= 3; i++) x(1, 0, 4095, "t4_fullscale_track", 1, 0, 0, 0, 4);
    x(1, 0, 4095, "t4_fullscale_settle", 0, 1, 0, 0, 4);

    // Full-scale error with tolerance 4094 is out of band; error 4094 is in band.
    goal      = SW'(4095);
    tolerance = SW'(4094);
    x(1, 1, 0, "t4_start_b", 1, 0, 0, 0, 4);
    for (int i = 1; i <= 6; i++) x(1, 0, 0, "t4_out_of_band", 1, 0, 0, 0, 4);
    for (int i = 1; i <= 3; i++) x(1, 0, 1, "t4_edge_track", 1, 0, 0, 0, 4);
    x(1, 0, 1, "t4_edge_settle", 0, 1, 0, 0, 10);

    // Goal change after 3 in-band samples restarts counting (start issued in SETTLED).
    goal      = SW'(1000);
    tolerance = SW'(2);
    x(1, 1, 1000, "t5_start_from_settled", 1, 0, 0, 0, 10);
    for (int i = 1; i <= 3; i++) x(1, 0, 1000, "t5_pre_change", 1, 0, 0, 0, 10);
    goal = SW'(2000);
    x(1, 0, 2000, "t5_goal_change", 1, 0, 0, 0, 10);
    for (int i = 1; i <= 3; i++) x(1, 0, 2001, "t5_fresh", 1, 0, 0, 0, 10);
    x(1, 0, 1999, "t5_settle", 0, 1, 0, 0, 4);

    // Start in SETTLED clears elapsed and band counter.
    x(1, 1, 2000, "t6_restart", 1, 0, 0, 0, 4);
    x(1, 0, 2000, "t6_in1", 1, 0, 0, 0, 4);
    x(1, 0, 2000, "t6_in2", 1, 0, 0, 0, 4);
    x(1, 0, 2005, "t6_out", 1, 0, 0, 0, 4);
    for (int i = 1; i <= 3; i++) x(1, 0, 2002, "t6_track", 1, 0, 0, 0, 4);
    x(1, 0, 1998, "t6_settle", 0, 1, 0, 0, 7);
    last_rt = TW'(7);

`ifdef RAMP_SETTLE_RELOCK_EN
    x(1, 0, 2010, "rl_lost", 1, 0, 0, 1, 7);
    for (int i = 1; i <= 3; i++) x(1, 0, 2000, "rl_track", 1, 0, 0, 1, 7);
    x(1, 0, 2000, "rl_resettle", 0, 1, 0, 1, 4);
    x(0, 0, 2010, "rl_no_strobe", 0, 1, 0, 1, 4);
    last_rt = TW'(4);
`else
    x(1, 0, 2010, "settled_ignores_sample", 0, 1, 0, 0, 7);
`endif

    // Reset mid-TRACK, then reset together with start.
    x(1, 1, 2000, "t7_start", 1, 0, 0, 0, last_rt);
    x(1, 0, 2000, "t7_track", 1, 0, 0, 0, last_rt);
    reset = 1'b1;
    x(1, 0, 2000, "t7_reset_mid_track", 0, 0, 0, 0, 0);
    x(1, 1, 2000, "t7_reset_beats_start", 0, 0, 0, 0, 0);
    reset = 1'b0;
    x(1, 0, 2000, "t7_idle_after_reset", 0, 0, 0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ramp_settle_monitor.md
# ramp_settle_monitor

Watches a slewing signal, such as the output of the setpoint ramp generator or a measured output voltage, and decides when it has settled on its goal. Settled means within a tolerance band for a programmable number of consecutive enabled samples. It reports settled or timeout status and the measured settling time. It sits on the consumer side of the setpoint ramp, beside the control loop, and gates soft-start sequencing and fault handling.

## Interface
Parameters:
- signal_width, 12, width of goal, sample and tolerance (unsigned)
- settle_cycles, 16, consecutive in-band enabled samples required to declare settled (≥1)
- time_width, 16, width of the elapsed, timeout and ramp_time counters

Ports:
- aclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clock_enable  in  1  sample strobe; all counting is qualified by it
- start  in  1  single-cycle arm/re-arm pulse
- goal  in  signal_width  target value
- sample  in  signal_width  monitored value
- tolerance  in  signal_width  allowed absolute error (inclusive)
- timeout  in  time_width  maximum enabled samples allowed; 0 disables timeout
- busy  out  1  state is TRACK
- settled  out  1  state is SETTLED
- fault  out  1  state is FAULT
- ramp_time  out  time_width  enabled samples from arm to settle, inclusive
- settle_lost  out  1  sticky flag, present only with the relock feature

## Operation
- States: IDLE, TRACK, SETTLED, FAULT. All outputs are registered.
- The error is the absolute difference between goal and sample, computed at signal_width+1 bits with no wrap. in_band means error ≤ tolerance.
- IDLE:
  - start goes to TRACK.
  - On entry to TRACK, clear elapsed, clear band_cnt and capture goal_q = goal.
- TRACK, on each clock_enable cycle:
  - elapsed increments, saturating at all-ones.
  - band_cnt increments if in_band, otherwise it clears to 0.
  - If band_cnt == settle_cycles−1 and in_band: go to SETTLED and set ramp_time = elapsed+1.
  - Else if timeout≠0 and elapsed+1 ≥ timeout: go to FAULT and leave ramp_time unchanged.
  - If settle and timeout occur on the same sample, settle wins.
- TRACK, cycles without clock_enable: no counter or state change.
- Goal change while in TRACK (goal ≠ goal_q): band_cnt and elapsed clear and goal_q updates. This rule takes priority over counting in that cycle.
- start in any state: restart TRACK (clear elapsed and band_cnt, capture goal_q). This includes start while already in TRACK.
- SETTLED and FAULT hold until start or reset. ramp_time holds its last value until the next settle.

## Timing
- Reset values: state IDLE, busy 0, settled 0, fault 0, ramp_time 0, settle_lost 0. Internal counters are 0.
- start at cycle t: busy = 1 from t+1. A sample presented at cycle t is ignored. The first counted sample is the first enabled cycle ≥ t+1.
- Settle latency: settled rises one clock after the enabled cycle that completes settle_cycles consecutive in-band samples. busy falls on the same edge.
- fault rises one clock after the enabled cycle on which elapsed reaches timeout.
- Reset mid-TRACK returns every output to its reset value on the next edge.
- If reset and start are asserted together, reset wins.

## Configuration
- RAMP_SETTLE_RELOCK_EN defined:
  - In SETTLED, any enabled sample that is out of band sets settle_lost (sticky, cleared only by reset or start) and returns the block to TRACK.
  - That transition clears band_cnt and elapsed; goal_q is kept. A goal change while SETTLED does the same.
- Not defined:
  - SETTLED ignores sample and goal.
  - The settle_lost port is absent.

## Test plan
- signal_width=12, settle_cycles=4, tolerance=2, timeout=0, clock_enable always 1, goal=1000, sample=996,997,998,999,1000,1000 after start → settled rises 1 clock after the 4th in-band sample (the second 1000); ramp_time=6.
- Same settings with sample alternating 998/1003 → never settled. Then set timeout=50 → fault rises 1 clock after the 50th enabled sample; ramp_time stays 0.
- clock_enable every 4th cycle, in-band from the start, settle_cycles=4 → settled rises 1 clock after the 4th strobe; ramp_time=4.
- Boundary: goal=0, sample=4095, tolerance=4095 → in_band true with no wrap. goal=4095, sample=0, tolerance=4094 → out of band.
- Goal changed 1000→2000 mid-TRACK after 3 in-band samples → counters restart; settling requires 4 fresh in-band samples around 2000. start asserted in SETTLED and in FAULT → busy again next clock with counters cleared.
- RAMP_SETTLE_RELOCK_EN: after settling, one sample at goal+10 → settle_lost=1, busy=1 next clock. Then 4 in-band samples → settled=1 with settle_lost still 1. Reset asserted mid-TRACK → all outputs 0 next clock.
